// File: rtl/io_pad_arb_pkg.sv
// Shared state encoding, pad direction constants and parameter checks for the IO pad arbiter.
package io_pad_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    OWN  = 2'd2
  } arb_state_e;

  localparam logic DIR_READ  = 1'b0;
  localparam logic DIR_DRIVE = 1'b1;

  function automatic bit nreq_ok(input int nreq);
    return (nreq >= 2) && (nreq <= 8);
  endfunction

endpackage

// File: rtl/io_pad_arb_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after i_ptr, wrapping.
module io_pad_rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] i_eligible,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_winner,
  output logic            o_any
);

  logic [NREQ-1:0] w_rot;
  logic [NREQ-1:0] w_rot_win;

  // Rotate so the pointer sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    w_rot     = NREQ'({i_eligible, i_eligible} >> i_ptr);
    w_rot_win = w_rot & (-w_rot);
    o_winner  = NREQ'(({w_rot_win, w_rot_win} << i_ptr) >> NREQ);
  end

  assign o_any = |i_eligible;

endmodule

// File: rtl/io_pad_turnaround_arbiter.sv
// Round-robin owner of one bidirectional pad with tristate turnaround on direction change.
// Optional forced release of long owners when `IO_PAD_ARB_TIMEOUT_EN is defined.
module io_pad_turnaround_arbiter
  import io_pad_arb_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int TURN_CYCLES  = 2,
  parameter int MAX_HOLD     = 16,
  parameter int NoConfigBits = NREQ
) (
  input  logic                    UserCLK,
  input  logic                    resetn,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         dir,
  input  logic [NREQ-1:0]         wdata,
  output logic [NREQ-1:0]         gnt,
  output logic                    rdata,
  output logic                    rvalid,
  output logic                    busy,
  output logic                    I_top,
  output logic                    T_top,
  input  logic                    O_top,
  input  logic [NoConfigBits-1:0] ConfigBits
);

  localparam int PW = $clog2(NREQ);
  localparam int TW = (TURN_CYCLES > 0) ? $clog2(TURN_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TURN_LOAD = (TURN_CYCLES > 0) ? TW'(TURN_CYCLES - 1) : '0;

  if (!nreq_ok(NREQ) || (NoConfigBits != NREQ) || (MAX_HOLD < 1)) begin : g_bad_cfg
    $error("io_pad_turnaround_arbiter: unsupported parameter set");
  end

  arb_state_e      r_state;
  arb_state_e      w_state_nxt;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_owner_idx;
  logic [NREQ-1:0] r_own;
  logic            r_own_dir;
  logic            r_last_dir;
  logic [TW-1:0]   r_turn_cnt;
  logic [NREQ-1:0] r_gnt;
  logic            r_i_top;
  logic            r_t_top;
  logic            r_rdata;
  logic            r_rvalid;

  logic [NREQ-1:0] w_elig;
  logic [NREQ-1:0] w_winner;
  logic            w_any;
  logic            w_win_dir;
  logic            w_own_req;
  logic            w_own_cfg;
  logic            w_own_wdata;
  logic            w_timeout;
  logic            w_latch;
  logic            w_grant;
  logic            w_release;
  logic [NREQ-1:0] w_gnt_oh;
  logic            w_gnt_dir;
  logic [PW-1:0]   w_ptr_nxt;

  function automatic logic [PW-1:0] oh2idx(input logic [NREQ-1:0] oh);
    logic [PW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) idx = idx | PW'(i);
    end
    return idx;
  endfunction

`ifdef IO_PAD_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0]   r_hold;
  logic [NREQ-1:0] r_evicted;

  // An evicted requester stays ineligible until it drops req once.
  assign w_elig    = req & ConfigBits & ~r_evicted;
  assign w_timeout = (r_hold == HW'(MAX_HOLD - 1)) && (|(w_elig & ~r_own));

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      r_hold    <= '0;
      r_evicted <= '0;
    end else begin
      if (w_grant) begin
        r_hold <= '0;
      end else if ((r_state == OWN) && (r_hold != HW'(MAX_HOLD - 1))) begin
        r_hold <= r_hold + HW'(1);
      end
      r_evicted <= (r_evicted & req) | ((w_release && w_timeout) ? r_own : '0);
    end
  end
`else
  assign w_elig    = req & ConfigBits;
  assign w_timeout = 1'b0;
`endif

  io_pad_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .i_eligible (w_elig),
    .i_ptr      (r_ptr),
    .o_winner   (w_winner),
    .o_any      (w_any)
  );

  assign w_win_dir   = |(w_winner & dir);
  assign w_own_req   = |(r_own & req);
  assign w_own_cfg   = |(r_own & ConfigBits);
  assign w_own_wdata = |(r_own & wdata);
  assign w_gnt_oh    = (r_state == IDLE) ? w_winner  : r_own;
  assign w_gnt_dir   = (r_state == IDLE) ? w_win_dir : r_own_dir;
  assign w_ptr_nxt   = (r_owner_idx == PW'(NREQ - 1)) ? '0 : r_owner_idx + PW'(1);

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_grant     = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_latch = 1'b1;
          if ((w_win_dir != r_last_dir) && (TURN_CYCLES > 0)) begin
            w_state_nxt = TURN;
          end else begin
            w_state_nxt = OWN;
            w_grant     = 1'b1;
          end
        end
      end
      TURN: begin
        if (!w_own_req) begin
          w_state_nxt = IDLE;
        end else if (r_turn_cnt == '0) begin
          w_state_nxt = OWN;
          w_grant     = 1'b1;
        end
      end
      OWN: begin
        if (!w_own_req || !w_own_cfg || w_timeout) begin
          w_state_nxt = IDLE;
          w_release   = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      r_ptr       <= '0;
      r_owner_idx <= '0;
      r_own       <= '0;
      r_own_dir   <= DIR_READ;
      r_last_dir  <= DIR_READ;
      r_turn_cnt  <= '0;
      r_gnt       <= '0;
      r_i_top     <= 1'b0;
      r_t_top     <= 1'b0;
      r_rdata     <= 1'b0;
      r_rvalid    <= 1'b0;
    end else begin
      r_rdata <= O_top;
      if (w_latch) begin
        r_own       <= w_winner;
        r_own_dir   <= w_win_dir;
        r_owner_idx <= oh2idx(w_winner);
        r_turn_cnt  <= TURN_LOAD;
      end else if (r_state == TURN) begin
        r_turn_cnt <= r_turn_cnt - TW'(1);
      end
      if (w_grant) begin
        r_gnt      <= w_gnt_oh;
        r_last_dir <= w_gnt_dir;
        if (w_gnt_dir == DIR_READ) r_t_top <= 1'b0;
      end else if (w_release) begin
        r_gnt    <= '0;
        r_rvalid <= 1'b0;
        r_ptr    <= w_ptr_nxt;
      end else if (r_state == OWN) begin
        if (r_own_dir == DIR_DRIVE) begin
          r_i_top <= w_own_wdata;
          r_t_top <= 1'b1;
        end else begin
          r_t_top  <= 1'b0;
          r_rvalid <= 1'b1;
        end
      end
      // The pad is released for the whole turnaround window.
      if (w_state_nxt == TURN) r_t_top <= 1'b0;
    end
  end

  assign gnt    = r_gnt;
  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
  assign busy   = (r_state != IDLE);
  assign I_top  = r_i_top;
  assign T_top  = r_t_top;

endmodule
